// File: rtl/oled_spi_sink.sv
// ---------------------------------------------------------------------------
// oled_spi_sink
//
// Receive-side model of a 96x64 OLED panel: the SPI slave sitting at the far
// end of the SpiMaster/OledInit link. Mode-0 SPI bytes are deserialised,
// split into command and pixel bytes by dc, the column/row window and
// display on/off commands are parsed, and every pixel byte becomes one
// framebuffer write with an auto-incrementing address that wraps inside the
// current window.
//
// Ports:
//   clk         system clock, at least 4x the sck frequency
//   reset       synchronous, active-high
//   sck         SPI clock from the master (asynchronous to clk)
//   mosi        SPI data, MSB first, sampled on sck rise
//   cs          chip select, active-low (asynchronous to clk)
//   dc          0 = command/argument byte, 1 = pixel byte (sampled with bit 0)
//   pix_we      one-cycle framebuffer write strobe
//   pix_addr    framebuffer address, cur_row*H_RES + cur_col
//   pix_data    received pixel byte
//   display_on  set by command 0xAF, cleared by 0xAE
//   frame_done  one-cycle pulse with the write of the last pixel in the window
//   cmd_err     one-cycle pulse on an unrecognised command byte
// ---------------------------------------------------------------------------
module oled_spi_sink #(
  parameter int H_RES  = 96,
  parameter int V_RES  = 64,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sck,
  input  logic              mosi,
  input  logic              cs,
  input  logic              dc,
  output logic              pix_we,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [7:0]        pix_data,
  output logic              display_on,
  output logic              frame_done,
  output logic              cmd_err
);

  localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int ROW_W = (V_RES > 1) ? $clog2(V_RES) : 1;

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_RES - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_RES - 1);

  localparam logic [7:0] CMD_SET_COL = 8'h15;
  localparam logic [7:0] CMD_SET_ROW = 8'h75;
  localparam logic [7:0] CMD_DISP_ON = 8'hAF;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_COL_A,
    ST_COL_B,
    ST_ROW_A,
    ST_ROW_B
  } parse_state_t;

  // -------------------------------------------------------------------------
  // Input synchronisers
  // -------------------------------------------------------------------------
  logic [1:0] sck_sync;
  logic [1:0] mosi_sync;
  logic [1:0] cs_sync;
  logic [1:0] dc_sync;
  logic       sck_prev;

  logic sck_s;
  logic mosi_s;
  logic cs_s;
  logic dc_s;
  logic sck_rise;

  // Every SPI pin goes through two flops before use. mosi and dc share the
  // same delay as sck, so they are still the values the master set up for
  // the sck edge we detect. cs resets to the deselected level so nothing is
  // shifted until the link is really selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      dc_sync   <= 2'b00;
      sck_prev  <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], cs};
      dc_sync   <= {dc_sync[0], dc};
      sck_prev  <= sck_sync[1];
    end
  end

  assign sck_s    = sck_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign cs_s     = cs_sync[1];
  assign dc_s     = dc_sync[1];
  assign sck_rise = sck_s & ~sck_prev;

  // -------------------------------------------------------------------------
  // Byte deserialiser
  // -------------------------------------------------------------------------
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_dc;

  // Bits are shifted in MSB first on each synced sck rise while selected.
  // The eighth bit completes a byte, which is handed to the parser together
  // with dc for exactly one cycle; the 3-bit counter wraps back to zero by
  // itself. Deselecting throws away any partial byte but leaves the parser
  // untouched, so a command sequence may span several cs frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg  <= 8'h00;
      bit_cnt    <= 3'd0;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (cs_s) begin
        shift_reg <= 8'h00;
        bit_cnt   <= 3'd0;
      end else if (sck_rise) begin
        shift_reg <= {shift_reg[6:0], mosi_s};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_valid <= 1'b1;
          byte_data  <= {shift_reg[6:0], mosi_s};
          byte_dc    <= dc_s;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Argument clamping helpers
  // -------------------------------------------------------------------------
  function automatic logic [COL_W-1:0] clamp_col(input logic [7:0] v);
    if (int'(v) > H_RES - 1) begin
      return COL_MAX;
    end
    return COL_W'(v);
  endfunction

  function automatic logic [ROW_W-1:0] clamp_row(input logic [7:0] v);
    if (int'(v) > V_RES - 1) begin
      return ROW_MAX;
    end
    return ROW_W'(v);
  endfunction

  // -------------------------------------------------------------------------
  // Parser, window and pixel pointer
  // -------------------------------------------------------------------------
  parse_state_t state, state_next;

  logic [COL_W-1:0]  col_start, col_start_next;
  logic [COL_W-1:0]  col_end, col_end_next;
  logic [ROW_W-1:0]  row_start, row_start_next;
  logic [ROW_W-1:0]  row_end, row_end_next;
  logic [COL_W-1:0]  cur_col, cur_col_next;
  logic [ROW_W-1:0]  cur_row, cur_row_next;

  logic              display_on_next;
  logic              pix_we_next;
  logic [ADDR_W-1:0] pix_addr_next;
  logic [7:0]        pix_data_next;
  logic              frame_done_next;
  logic              cmd_err_next;

  logic [COL_W-1:0]  arg_col;
  logic [ROW_W-1:0]  arg_row;
  logic [ADDR_W-1:0] cur_addr;
  logic              at_col_end;
  logic              at_row_end;

  assign arg_col    = clamp_col(byte_data);
  assign arg_row    = clamp_row(byte_data);
  assign cur_addr   = ADDR_W'(cur_row) * ADDR_W'(H_RES) + ADDR_W'(cur_col);
  assign at_col_end = (cur_col == col_end);
  assign at_row_end = (cur_row == row_end);

  // State and datapath register: the FSM, the window, the pointer and the
  // registered outputs all load their next values here. Reset restores the
  // full-panel window with the pointer at the top-left pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CMD;
      col_start  <= '0;
      col_end    <= COL_MAX;
      row_start  <= '0;
      row_end    <= ROW_MAX;
      cur_col    <= '0;
      cur_row    <= '0;
      display_on <= 1'b0;
      pix_we     <= 1'b0;
      pix_addr   <= '0;
      pix_data   <= 8'h00;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      state      <= state_next;
      col_start  <= col_start_next;
      col_end    <= col_end_next;
      row_start  <= row_start_next;
      row_end    <= row_end_next;
      cur_col    <= cur_col_next;
      cur_row    <= cur_row_next;
      display_on <= display_on_next;
      pix_we     <= pix_we_next;
      pix_addr   <= pix_addr_next;
      pix_data   <= pix_data_next;
      frame_done <= frame_done_next;
      cmd_err    <= cmd_err_next;
    end
  end

  // Next-state logic. Pixel bytes are handled independently of the parser
  // state, so data can arrive between a command and its arguments without
  // disturbing the sequence. Command bytes walk the FSM; the second argument
  // of a window command also rewinds the pointer on that axis. An end value
  // below its start collapses the window to a single column/row.
  always_comb begin
    state_next      = state;
    col_start_next  = col_start;
    col_end_next    = col_end;
    row_start_next  = row_start;
    row_end_next    = row_end;
    cur_col_next    = cur_col;
    cur_row_next    = cur_row;
    display_on_next = display_on;
    pix_we_next     = 1'b0;
    pix_addr_next   = pix_addr;
    pix_data_next   = pix_data;
    frame_done_next = 1'b0;
    cmd_err_next    = 1'b0;

    if (byte_valid && byte_dc) begin
      pix_we_next     = 1'b1;
      pix_addr_next   = cur_addr;
      pix_data_next   = byte_data;
      frame_done_next = at_col_end && at_row_end;
      if (!at_col_end) begin
        cur_col_next = cur_col + COL_W'(1);
      end else begin
        cur_col_next = col_start;
        cur_row_next = at_row_end ? row_start : cur_row + ROW_W'(1);
      end
    end else if (byte_valid) begin
      case (state)
        ST_CMD: begin
          if (byte_data == CMD_SET_COL) begin
            state_next = ST_COL_A;
          end else if (byte_data == CMD_SET_ROW) begin
            state_next = ST_ROW_A;
          end else if (byte_data == CMD_DISP_ON) begin
            display_on_next = 1'b1;
          end else if (byte_data == CMD_DISP_OFF) begin
            display_on_next = 1'b0;
          end else begin
            cmd_err_next = 1'b1;
          end
        end
        ST_COL_A: begin
          col_start_next = arg_col;
          state_next     = ST_COL_B;
        end
        ST_COL_B: begin
          col_end_next = (arg_col < col_start) ? col_start : arg_col;
          cur_col_next = col_start;
          state_next   = ST_CMD;
        end
        ST_ROW_A: begin
          row_start_next = arg_row;
          state_next     = ST_ROW_B;
        end
        ST_ROW_B: begin
          row_end_next = (arg_row < row_start) ? row_start : arg_row;
          cur_row_next = row_start;
          state_next   = ST_CMD;
        end
        default: begin
          state_next = ST_CMD;
        end
      endcase
    end
  end

endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- Receive-side model of the 96x64 OLED panel: the SPI slave at the far end of the SpiMaster/OledInit link.
- Deserialises mode-0 SPI bytes and splits them into command and pixel-data bytes using dc.
- Parses the column/row window and display-on/off commands.
- Emits one framebuffer write per pixel byte, with address auto-increment and wrap inside the window.
- Used as the display model in system benches and as the input stage of an on-chip video mirror.

Parameters:
- H_RES, 96, panel columns.
- V_RES, 64, panel rows.
- ADDR_W, 13, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk  in  1  system clock; must be >= 4x sck frequency.
- reset  in  1  synchronous, active-high.
- sck  in  1  SPI clock from the master; asynchronous.
- mosi  in  1  SPI data, MSB first, sampled on sck rise.
- cs  in  1  chip select, active-low; asynchronous.
- dc  in  1  0 = command/argument byte, 1 = pixel data byte; sampled with bit 0.
- pix_we  out  1  one-cycle framebuffer write strobe.
- pix_addr  out  ADDR_W  cur_row*H_RES + cur_col.
- pix_data  out  8  received pixel byte (8-bit colour).
- display_on  out  1  set by 0xAF, cleared by 0xAE.
- frame_done  out  1  one-cycle pulse when the last pixel of the window is written.
- cmd_err  out  1  one-cycle pulse on an unrecognised command byte.

Behaviour:
- Input sync: sck, mosi, cs and dc each pass through a 2-flop synchroniser; an sck rise is detected on synced sck = 1 with previous = 0.
- Shift:
  - On each detected rise with synced cs = 0: shift mosi into an 8-bit register and increment a 3-bit bit counter.
  - On the 8th bit: latch the byte together with the synced dc, raise byte_valid for one cycle, reset the counter.
- cs deassert (synced cs = 1): clear the bit counter and discard the partial byte. Parser state and window are kept; cs high never aborts a command sequence.
- Parser FSM, advanced only on byte_valid with dc = 0:
  - CMD state:
    - 0x15 -> COL_A; 0x75 -> ROW_A.
    - 0xAF sets display_on, 0xAE clears it; both stay in CMD.
    - Any other byte: pulse cmd_err, stay in CMD.
  - COL_A: store col_start -> COL_B.
  - COL_B: store col_end; set cur_col = col_start -> CMD.
  - ROW_A: store row_start -> ROW_B.
  - ROW_B: store row_end; set cur_row = row_start -> CMD.
- Argument rules:
  - Column arguments above H_RES-1 clamp to H_RES-1; row arguments above V_RES-1 clamp to V_RES-1.
  - If end < start after clamping, end := start.
- Pixel bytes (dc = 1):
  - Accepted in any FSM state; they do not disturb the FSM.
  - Each one produces pix_we = 1 with pix_addr taken from the current pointer and pix_data = the byte.
  - The pointer then advances:
    - If cur_col != col_end: cur_col + 1.
    - Otherwise: cur_col = col_start, and cur_row = (cur_row == row_end) ? row_start : cur_row + 1.
  - frame_done pulses in the same cycle as pix_we when cur_col == col_end and cur_row == row_end.
- Latency: pix_we, cmd_err and the display_on update take effect on the 4th clk rising edge, counting the edge that first samples the raw 8th sck high as edge 1 (2 sync + detect/shift + output register).
- Output registers: pix_addr and pix_data are registered and hold their value until the next write.
- Reset values:
  - pix_we = 0, pix_addr = 0, pix_data = 0, display_on = 0, frame_done = 0, cmd_err = 0.
  - FSM = CMD, bit counter = 0.
  - Window = 0..H_RES-1 by 0..V_RES-1; cur_col = cur_row = 0.
- Reset mid-byte or mid-command: everything returns to the reset values on the next clk edge; a partial byte is lost.
- Arithmetic: pix_addr is computed at ADDR_W bits with no overflow for the default parameters (max 6143).

Test Plan:
- Reset, then 3 pixel bytes 0x11, 0x22, 0x33 (dc = 1) -> writes at addr 0, 1, 2 with those data; each pix_we exactly 1 cycle, 4 clk after the 8th sck rise.
- Commands 0x15, 10, 12, 0x75, 5, 6, then 6 pixel bytes -> addrs 490, 491, 492, 586, 587, 588; frame_done on the 6th; a 7th pixel byte -> addr 490.
- Command 0x15 with arguments 200, 3 -> col_start = 95, col_end = 95; next pixel at col 95 of the current row, and every following pixel moves down one row.
- cs raised after 5 bits, then a full byte 0xAF (dc = 0) -> display_on = 1, no cmd_err, no pix_we; then 0xAE -> display_on = 0.
- Byte 0x42 (dc = 0) in CMD -> cmd_err pulses 1 cycle; 0x15, cs high, cs low, then 0x04, 0x07 -> window set (FSM survives cs).
- reset asserted between the two arguments of 0x75 -> window back to 0..63 rows, FSM = CMD; next pixel at addr 0.
